// File: rtl/label_pkg.sv
// Shared state encoding and default sizing for the label streaming/argmax blocks.
package label_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int LABEL_N                      = 8;
  localparam int LABEL_NUMBER_OF_LABELS       = 10;
  localparam int LABEL_CLOG2_NUMBER_OF_LABELS = 4;
  localparam int LABEL_OUTPUT_SIZE            = 10;

endpackage

// File: rtl/label_vector_streamer.sv
// Turns an accepted label into a one-hot vector, streamed word by word with valid/ready.
// Optional out-of-range label detection is enabled by defining LABEL_RANGE_CHECK_EN.
module label_vector_streamer
  import label_pkg::*;
#(
  parameter int             n                      = LABEL_N,
  parameter int             number_of_labels       = LABEL_NUMBER_OF_LABELS,
  parameter int             clog2_number_of_labels = LABEL_CLOG2_NUMBER_OF_LABELS,
  parameter int             output_size            = LABEL_OUTPUT_SIZE,
  parameter logic [n-1:0]   hot_value              = {1'b0, {(n-1){1'b1}}}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [clog2_number_of_labels-1:0] label,
  input  logic                              label_valid,
  output logic                              label_ready,
  output logic [n-1:0]                      out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [n*output_size-1:0]         vector,
  output logic                              err
);

  localparam int IW = (output_size > 1) ? $clog2(output_size) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(output_size - 1);

  state_t                            state_q, state_d;
  logic [IW-1:0]                     idx_q, idx_d;
  logic [clog2_number_of_labels-1:0] label_q, label_d;
  logic [n*output_size-1:0]          vector_q, vector_d, vector_load;
  logic                              bad_q, bad_d;
  logic                              label_bad;
  logic                              accept;
  logic                              beat;
  logic                              idx_hit;

`ifdef LABEL_RANGE_CHECK_EN
  assign label_bad = 32'(label) >= 32'(number_of_labels);
`else
  assign label_bad = 1'b0;
`endif

  assign accept  = label_valid && label_ready;
  assign beat    = out_valid && out_ready;
  // A rejected label keeps the whole vector zero, so the hot word is suppressed too.
  assign idx_hit = (32'(idx_q) == 32'(label_q)) && !bad_q;

  for (genvar gi = 0; gi < output_size; gi++) begin : g_word
    assign vector_load[n*gi +: n] = ((32'(label) == gi) && !label_bad) ? hot_value : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (label_valid) state_d = STREAM;
      STREAM:  if (out_ready && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    label_ready = (state_q == IDLE);
    out_valid   = (state_q == STREAM);
    out_last    = out_valid && (idx_q == LAST_IDX);
    out_data    = (out_valid && idx_hit) ? hot_value : '0;
  end

  always_comb begin
    idx_d    = idx_q;
    label_d  = label_q;
    vector_d = vector_q;
    bad_d    = bad_q;
    if (accept) begin
      idx_d    = '0;
      label_d  = label;
      vector_d = vector_load;
      bad_d    = label_bad;
    end else if (beat && !out_last) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      label_q  <= '0;
      vector_q <= '0;
      bad_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      label_q  <= label_d;
      vector_q <= vector_d;
      bad_q    <= bad_d;
    end
  end

  assign vector = vector_q;

`ifdef LABEL_RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && label_bad;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_label_vector_streamer.sv
// Bench for label_vector_streamer: table-driven streams, hand-written corner sequences
// and random streams checked against a per-word model of the one-hot output.
module tb_label_vector_streamer;

  localparam int N   = 8;
  localparam int NL  = 10;
  localparam int CLW = 4;
  localparam int OS  = 10;
  localparam logic [N-1:0] HOT = 8'h7F;
`ifdef LABEL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [CLW-1:0]  label;
  logic            label_valid;
  logic            label_ready;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [N*OS-1:0] vector;
  logic            err;

  int checks = 0;
  int errors = 0;

  label_vector_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .label       (label),
    .label_valid (label_valid),
    .label_ready (label_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .vector      (vector),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit in_range(int lab);
    return !RC || (lab < NL);
  endfunction

  function automatic logic [N-1:0] model_word(int lab, int i);
    return (i == lab && in_range(lab)) ? HOT : '0;
  endfunction

  function automatic logic [N*OS-1:0] model_vec(int lab);
    logic [N*OS-1:0] v;
    v = '0;
    for (int i = 0; i < OS; i++) v[N*i +: N] = model_word(lab, i);
    return v;
  endfunction

  function automatic int model_hot(int lab);
    return (in_range(lab) && lab < OS) ? lab : -1;
  endfunction

  // Called on a falling edge. mode: 0 ready always, 1 ready alternating, 2 random.
  // next_lab >= 0 keeps label_valid high with that label during the stream.
  // abort_at >= 0 asserts reset while that word is on the output.
  task automatic run_stream(input int lab, input int mode, input int next_lab,
                            input int abort_at, output int beats, output int hot_at);
    int cyc;
    bit rdy;
    beats  = 0;
    hot_at = -1;
    cyc    = 0;
    chk("ready_before_accept", label_ready, 1);
    label       = CLW'(lab);
    label_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (next_lab >= 0) label = CLW'(next_lab);
    else label_valid = 1'b0;
    chk("err_pulse", err, (RC && lab >= NL) ? 1 : 0);
    chk("vector_load", vector, model_vec(lab));
    chk("ready_in_stream", label_ready, 0);
    while (beats < OS && cyc < 200) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, model_word(lab, beats));
      chk("out_last", out_last, (beats == OS - 1) ? 1 : 0);
      if (out_data != '0 && hot_at < 0) hot_at = beats;
      if (beats == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_label_ready", label_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_vector", vector, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst         = 1'b0;
        label_valid = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", label_ready, 1);
        chk("valid_after_reset", out_valid, 0);
        $display("stream label=%0d aborted by reset at word %0d", lab, beats);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      @(posedge clk);
      if (rdy) beats++;
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("err_one_cycle", err, 0);
    end
    out_ready = 1'b0;
    chk("beat_count", beats, OS);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_label_ready", label_ready, 1);
    chk("vector_hold", vector, model_vec(lab));
    $display("stream label=%0d mode=%0d beats=%0d cycles=%0d hot_word=%0d",
             lab, mode, beats, cyc, hot_at);
  endtask

  typedef struct {
    int lab;
    int mode;
    int exp_hot;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int b, h, lab;

    tbl[0] = '{lab: 3,  mode: 0, exp_hot: 3};
    tbl[1] = '{lab: 0,  mode: 1, exp_hot: 0};
    tbl[2] = '{lab: 9,  mode: 2, exp_hot: 9};
    tbl[3] = '{lab: 7,  mode: 1, exp_hot: 7};
    tbl[4] = '{lab: 12, mode: 0, exp_hot: -1};

    rst         = 1'b1;
    label       = '0;
    label_valid = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_vector", vector, 0);
    chk("reset_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_first_clock", label_ready, 1);
    $display("reset released, label_ready=%0d", label_ready);

    for (int i = 0; i < 5; i++) begin
      run_stream(tbl[i].lab, tbl[i].mode, -1, -1, b, h);
      chk("table_hot_position", h, tbl[i].exp_hot);
    end

    // label_valid stays high with a new label during a stream
    run_stream(9, 0, 2, -1, b, h);
    chk("ignored_label_hot", h, 9);
    run_stream(2, 0, -1, -1, b, h);
    chk("second_label_hot", h, 2);

    // reset in the middle of a vector, then a clean stream
    run_stream(7, 0, -1, 5, b, h);
    run_stream(1, 0, -1, -1, b, h);
    chk("post_reset_hot", h, 1);

    for (int i = 0; i < 20; i++) begin
      lab = int'($urandom_range(0, 15));
      run_stream(lab, 2, -1, -1, b, h);
      chk("random_hot_position", h, model_hot(lab));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
